// File: rtl/alu_pkg.sv
// Shared opcode values and FSM state encoding for alu_seq, its multiplier and the bench.
// The optional multiplier is selected with the ALU_MUL_EN macro in alu_seq.
package alu_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_DEC  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles from start to a one-cycle
// done pulse, with the full 2*WIDTH product held on product until the next start.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // Last multiplier bit consumed this cycle: product is final after this edge.
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and z/c/n/err flags. Define ALU_MUL_EN to build the
// WIDTH-cycle multiplier; otherwise opcode 111 completes in one cycle and raises flag_err.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             alu_clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] accum,
    input  logic [WIDTH-1:0] data,
    output logic             acc_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_err,
    output alu_state_e       dbg_state
);

    // Handshake: an input transfer happens on a clock edge where in_valid && in_ready; an output
    // transfer where out_valid && out_ready. out_valid and the result stay stable until taken.

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             z_q, z_d, c_q, c_d, n_q, n_d, err_q, err_d;

    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic [WIDTH:0]   ext_r;
    logic             err_r;

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign acc_zero = (accum == '0);

`ifdef ALU_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul = (opcode == OP_MUL);
    assign err_r  = 1'b0;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (alu_clk),
        .rst     (reset),
        .start   (mul_start),
        .a       (accum),
        .b       (data),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign is_mul = 1'b0;
    assign err_r  = (opcode == OP_MUL);
`endif

    // One extra bit carries the carry-out / borrow of the single-cycle operations.
    always_comb begin
        ext_r = '0;
        case (opcode)
            OP_PASS: ext_r = {1'b0, accum};
            OP_INC:  ext_r = {1'b0, accum} + {{WIDTH{1'b0}}, 1'b1};
            OP_DEC:  ext_r = {1'b0, accum} - {{WIDTH{1'b0}}, 1'b1};
            OP_ADD:  ext_r = {1'b0, accum} + {1'b0, data};
            OP_SUB:  ext_r = {1'b0, accum} - {1'b0, data};
            OP_AND:  ext_r = {1'b0, accum & data};
            OP_XOR:  ext_r = {1'b0, accum ^ data};
            default: ext_r = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        z_d       = z_q;
        c_d       = c_q;
        n_d       = n_q;
        err_d     = err_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        res_d   = ext_r[WIDTH-1:0];
                        z_d     = (ext_r[WIDTH-1:0] == '0);
                        c_d     = ext_r[WIDTH];
                        n_d     = ext_r[WIDTH-1];
                        err_d   = err_r;
                        state_d = ST_HOLD;
                    end
                end else if ((state_q == ST_HOLD) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    res_d   = mul_prod[WIDTH-1:0];
                    z_d     = (mul_prod[WIDTH-1:0] == '0);
                    c_d     = |mul_prod[2*WIDTH-1:WIDTH];
                    n_d     = mul_prod[WIDTH-1];
                    err_d   = 1'b0;
                    state_d = ST_HOLD;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge alu_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            z_q     <= z_d;
            c_q     <= c_d;
            n_q     <= n_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign alu_out   = res_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_n    = n_q;
    assign flag_err  = err_q;
    assign dbg_state = state_q;

endmodule
